// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
// The state encoding is exported here so benches can decode the FSM.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_SUM    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam int LEN_W = 16;

    // Widened compare so a 16-bit length never aliases against the depth.
    function automatic logic len_too_big(input logic [LEN_W-1:0] len,
                                         input int unsigned       depth);
        return ({1'b0, len} > 17'(depth));
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8-to-32 shift assembler: first byte lands in bits 31:24, word_valid
// pulses combinationally with the 4th byte of each word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;

    // Byte shift register and position-in-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= 24'd0;
            cnt_r   <= 2'd0;
        end else if (en) begin
            shift_r <= {shift_r[15:0], data};
            cnt_r   <= cnt_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    assign word       = {shift_r, data};
    assign word_valid = en && (cnt_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses length, data words and an XOR checksum,
// writes imem, and releases the processor only after a verified image.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WORD   = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_in,
    output logic              mem_we,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t              state_r, state_nxt_s;
    logic [7:0]          len_hi_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    len_full_s;
    logic [7:0]          xor_r;
    logic [ADDR_W:0]     wcnt_r;
    logic [ADDR_W:0]     wcnt_inc_s;
    logic                last_word_s;
    logic                pk_en_s;
    logic [31:0]         pk_word_s;
    logic                pk_valid_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_in_r;
    logic                mem_we_r;
    logic                cpu_rst_r;
    logic                done_r;
    logic                err_r;

    assign len_full_s  = {len_hi_r, rx_data};
    assign wcnt_inc_s  = wcnt_r + {{ADDR_W{1'b0}}, 1'b1};
    // Word counter is one bit wider than the address so N == WORD is reachable.
    assign last_word_s = (17'(wcnt_inc_s) == {1'b0, len_r});

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .en         (pk_en_s),
        .data       (rx_data),
        .word       (pk_word_s),
        .word_valid (pk_valid_s)
    );

    // Next-state decode and packer enable.
    always_comb begin
        state_nxt_s = state_r;
        pk_en_s     = 1'b0;
        case (state_r)
            S_LEN_HI: begin
                if (rx_valid) state_nxt_s = S_LEN_LO;
                else          state_nxt_s = state_r;
            end
            S_LEN_LO: begin
                if (!rx_valid)                        state_nxt_s = state_r;
                else if (len_too_big(len_full_s, WORD)) state_nxt_s = S_ERR;
                else if (len_full_s == 16'd0)         state_nxt_s = S_SUM;
                else                                  state_nxt_s = S_DATA;
            end
            S_DATA: begin
                pk_en_s = rx_valid;
                if (pk_valid_s && last_word_s) state_nxt_s = S_SUM;
                else                           state_nxt_s = state_r;
            end
            S_SUM: begin
                if (!rx_valid)              state_nxt_s = state_r;
                else if (rx_data == xor_r)  state_nxt_s = S_DONE;
                else                        state_nxt_s = S_ERR;
            end
            S_DONE:  state_nxt_s = S_DONE;
            S_ERR:   state_nxt_s = S_ERR;
            default: state_nxt_s = S_ERR;
        endcase
    end

    // State, length, checksum, word counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_LEN_HI;
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            xor_r      <= 8'd0;
            wcnt_r     <= '0;
            mem_addr_r <= '0;
            mem_in_r   <= 32'd0;
            mem_we_r   <= 1'b0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            mem_we_r <= pk_valid_s;
            if (pk_valid_s) begin
                mem_addr_r <= wcnt_r[ADDR_W-1:0];
                mem_in_r   <= pk_word_s;
                wcnt_r     <= wcnt_inc_s;
            end
            if (rx_valid && (state_r == S_LEN_HI || state_r == S_LEN_LO || state_r == S_DATA))
                xor_r <= xor_r ^ rx_data;
            if (rx_valid && state_r == S_LEN_HI)
                len_hi_r <= rx_data;
            if (rx_valid && state_r == S_LEN_LO)
                len_r <= len_full_s;
            done_r    <= (state_nxt_s == S_DONE);
            err_r     <= (state_nxt_s == S_ERR);
            cpu_rst_r <= (state_nxt_s != S_DONE);
        end
    end

    assign mem_addr = mem_addr_r;
    assign mem_in   = mem_in_r;
    assign mem_we   = mem_we_r;
    assign cpu_rst  = cpu_rst_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; a negedge monitor logs every
// imem write with its cycle number for the scenario tasks to inspect.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_we;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [7:0]  strm[$];

    always #5 clk = ~clk;

    imem_loader #(.WORD(4096), .ADDR_W(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_we   (mem_we),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_in);
            wc.push_back(cyc);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // A byte offered during reset must be dropped.
    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x = 8'h00;
        foreach (strm[i]) x = x ^ strm[i];
        return x;
    endfunction

    task automatic build_two_words();
        strm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        do_reset();
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 12'd0) begin errors++; $display("FAIL rst_mem_addr got %0h want 0", mem_addr); end
        checks++; if (mem_in !== 32'd0)   begin errors++; $display("FAIL rst_mem_in got %0h want 0", mem_in); end
        checks++; if ({cpu_rst, done, err} !== 3'b100) begin errors++; $display("FAIL rst_flags got %b want 100", {cpu_rst, done, err}); end
    endtask

    task automatic run_two_words(input string nm, input int gap, input logic [7:0] sum_flip);
        int base;
        int done_cyc;
        do_reset();
        build_two_words();
        base = wa.size();
        foreach (strm[i]) send(strm[i], gap);
        send(xsum() ^ sum_flip, 0);
        done_cyc = cyc;
        if (sum_flip == 8'h00) begin
            checks++; if ({done, cpu_rst, err} !== 3'b100) begin errors++; $display("FAIL %s_release got done,cpu_rst,err=%b want 100", nm, {done, cpu_rst, err}); end
        end else begin
            checks++; if ({done, cpu_rst, err} !== 3'b011) begin errors++; $display("FAIL %s_badsum got done,cpu_rst,err=%b want 011", nm, {done, cpu_rst, err}); end
        end
        checks++;
        if (wa.size() - base !== 2) begin
            errors++; $display("FAIL %s_write_count got %0d want 2", nm, wa.size() - base);
        end else begin
            checks++; if (wa[base] !== 12'd0 || wd[base] !== 32'h12345678) begin errors++; $display("FAIL %s_word0 got %0h@%0h want 12345678@0", nm, wd[base], wa[base]); end
            checks++; if (wa[base+1] !== 12'd1 || wd[base+1] !== 32'h9ABCDEF0) begin errors++; $display("FAIL %s_word1 got %0h@%0h want 9abcdef0@1", nm, wd[base+1], wa[base+1]); end
            checks++; if (wc[base+1] - wc[base] !== 4 * (gap + 1)) begin errors++; $display("FAIL %s_spacing got %0d want %0d", nm, wc[base+1] - wc[base], 4 * (gap + 1)); end
            checks++; if (wc[base+1] > done_cyc) begin errors++; $display("FAIL %s_last_write_order got cyc %0d want <= %0d", nm, wc[base+1], done_cyc); end
        end
    endtask

    task automatic test_back_to_back();
        run_two_words("b2b", 0, 8'h00);
    endtask

    task automatic test_idle_gaps();
        run_two_words("gap", 1, 8'h00);
    endtask

    task automatic test_bad_checksum();
        run_two_words("bad", 0, 8'h03);
    endtask

    task automatic test_len_over();
        int base;
        do_reset();
        send(8'h10, 0);
        send(8'h01, 0);
        checks++; if ({err, cpu_rst, done} !== 3'b110) begin errors++; $display("FAIL len_over_flags got err,cpu_rst,done=%b want 110", {err, cpu_rst, done}); end
        base = wa.size();
        for (int i = 0; i < 8; i++) send(8'(i * 17), 0);
        @(negedge clk);
        checks++; if (wa.size() !== base) begin errors++; $display("FAIL len_over_writes got %0d want 0", wa.size() - base); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL len_over_sticky got %0b want 1", err); end
    endtask

    task automatic test_len_zero();
        int base;
        do_reset();
        base = wa.size();
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        checks++; if ({done, cpu_rst, err} !== 3'b100) begin errors++; $display("FAIL len_zero_done got done,cpu_rst,err=%b want 100", {done, cpu_rst, err}); end
        send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0);
        send(8'h56, 0); send(8'h78, 0); send(8'hFF, 0);
        @(negedge clk);
        checks++; if (wa.size() !== base) begin errors++; $display("FAIL len_zero_writes got %0d want 0", wa.size() - base); end
        checks++; if ({done, cpu_rst, err} !== 3'b100) begin errors++; $display("FAIL len_zero_sticky got %b want 100", {done, cpu_rst, err}); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        build_two_words();
        for (int i = 0; i < 8; i++) send(strm[i], 0);
        do_reset();
        base = wa.size();
        strm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        foreach (strm[i]) send(strm[i], 0);
        send(xsum(), 0);
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL mid_rst_done got done,cpu_rst=%b want 10", {done, cpu_rst}); end
        checks++;
        if (wa.size() - base !== 1) begin
            errors++; $display("FAIL mid_rst_writes got %0d want 1", wa.size() - base);
        end else begin
            checks++; if (wa[base] !== 12'd0 || wd[base] !== 32'hAABBCCDD) begin errors++; $display("FAIL mid_rst_word got %0h@%0h want aabbccdd@0", wd[base], wa[base]); end
        end
    endtask

    // Full-depth image: the word counter must reach 4096 without wrapping.
    task automatic test_full_depth();
        int base;
        int bad;
        logic [7:0]  x;
        logic [15:0] k;
        logic [31:0] w;
        do_reset();
        base = wa.size();
        x = 8'h10 ^ 8'h00;
        send(8'h10, 0);
        send(8'h00, 0);
        for (int i = 0; i < 4096; i++) begin
            k = 16'(i);
            w = {k, ~k};
            for (int b = 3; b >= 0; b--) begin
                x = x ^ w[b*8 +: 8];
                send(w[b*8 +: 8], 0);
            end
        end
        send(x, 0);
        checks++; if ({done, cpu_rst, err} !== 3'b100) begin errors++; $display("FAIL full_done got done,cpu_rst,err=%b want 100", {done, cpu_rst, err}); end
        checks++;
        if (wa.size() - base !== 4096) begin
            errors++; $display("FAIL full_count got %0d want 4096", wa.size() - base);
        end else begin
            bad = 0;
            for (int i = 0; i < 4096; i++) begin
                k = 16'(i);
                if (wa[base+i] !== k[11:0] || wd[base+i] !== {k, ~k}) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL full_contents got %0d bad words want 0", bad); end
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_idle_gaps();
        test_bad_checksum();
        test_len_over();
        test_len_zero();
        test_mid_reset();
        test_full_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
